sha256_msg_padder: RTL and testbench
====================================

# sha256_msg_padder

Upstream stage of the SHA-256 core. Accepts an arbitrary-length byte stream over a valid/ready handshake and emits FIPS 180-4 padded 512-bit blocks. For each block, the outputs map directly onto the core's w0..w15 message-word inputs. Flags tell the core whether to load the NIST IV (first block) or chain from its previous digest, and whether the block is the final one.

## Interface
- LEN_W, 64, width of the internal bit-length counter; the length field is zero-extended to 64 bits.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  padder accepts a byte this cycle.
- in_data  in  8  message byte; first byte lands in w0[31:24].
- in_last  in  1  marks final byte of message; messages are ≥1 byte.
- blk_valid  out  1  blk_words holds a complete block.
- blk_ready  in  1  core accepts block (its start/idle condition).
- blk_words  out  512  w0 in [511:480] … w15 in [31:0], big-endian bytes.
- blk_first  out  1  block is first of its message; core uses the IV.
- blk_last  out  1  block is final; digest valid after this block.

## Operation
- States: FILL, PAD, PAD2, EMIT.
- **FILL:** in_ready=1. Each handshake writes the byte at index p (0..63), increments p and adds 8 to bitlen.
- **FILL → EMIT:** on a non-last byte with p=63.
- **FILL → PAD:** on a last byte; pend_len=1.
- **PAD:** let q = p after the last byte.
  - q≤55: write 0x80 at q, zeros to byte 55, bitlen (big-endian 64-bit) at bytes 56..63. Set last_flag. → EMIT.
  - 56≤q≤63: write 0x80 at q, zeros to 63. last_flag=0, need_len=1. → EMIT.
  - q=64: no write, need_len=1, pad80_next=1. → EMIT.
- **EMIT:** blk_valid=1, in_ready=0. On blk_valid&blk_ready:
  - Clear buffer, p=0.
  - If blk_last: clear first_flag to 1 and bitlen to 0, then → FILL.
  - Else if need_len: → PAD2.
  - Else: first_flag=0, → FILL.
- **PAD2:** buffer=0, byte0=0x80 if pad80_next, bytes 56..63=bitlen, last_flag=1, first_flag=0. → EMIT.
- blk_first=first_flag and blk_last=last_flag, both held stable throughout EMIT.
- bitlen wraps modulo 2^LEN_W; no error is raised.
- blk_words, blk_first and blk_last are stable while blk_valid=1 and blk_ready=0.

## Timing
- Reset (async) values:
  - state=FILL, so in_ready=1 once reset is low.
  - blk_valid=0, blk_words=0, blk_first=1, blk_last=0.
- Full non-last block: 64th byte accepted at edge k → blk_valid=1 from edge k.
- Last byte accepted at edge k → PAD during cycle k..k+1 → blk_valid=1 from edge k+1.
- Second pad block: appears 2 edges after the first block's handshake (PAD2, then EMIT).
- Throughput is 64 bytes per 64 + 1 + stall cycles. No input is accepted while in PAD, PAD2 or EMIT.
- Simultaneous in_valid with state≠FILL: ignored, since in_ready=0.
- Reset mid-message or mid-EMIT: partial block discarded, blk_valid drops immediately, and the next byte starts a new message with blk_first=1.

## Configuration
- SHA256_PAD_BLKCNT_EN defined:
  - Adds output blk_count[15:0], the number of blocks handed over since reset, incremented on each blk_valid&blk_ready and wrapping at 0xFFFF.
  - Adds output msg_count[15:0], incremented on each handshake with blk_last=1.
  - Both reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package sha256_pkg contains:
  - the pad state enum;
  - constants BLOCK_BYTES=64, LEN_OFS=56, PAD_BYTE=8'h80;
  - the SHA-256 IV constants, shared with the core's bench and top.
- Single module; no sub-module warranted. Byte-lane write decode stays inline.

## Test plan
- "abc" + in_last, blk_ready=1 → one block: w0=61626380, w1..w14=0, w15=00000018, blk_first=1, blk_last=1. Fed to the core it yields ba7816bf…f20015ad.
- 55×0x61 → one block: w13=61616180, w15=000001B8, blk_first=blk_last=1.
- 56×0x61 → block A: w14=80000000, w15=0, blk_last=0. Block B: all zero except w15=000001C0, blk_first=0, blk_last=1.
- 64×0x61 → block A: all words 61616161, blk_first=1, blk_last=0. Block B: w0=80000000, w15=00000200, blk_last=1.
- Backpressure: blk_ready low for 10 cycles during EMIT → blk_words and flags constant, in_ready=0, then exactly one handshake.
- Reset after 30 bytes, then "abc" → single block identical to the first scenario with blk_first=1; with SHA256_PAD_BLKCNT_EN, blk_count=1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: message padder state encoding, block geometry
// constants and the standard initial hash value used by the compression core.
package sha256_pkg;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_PAD  = 2'd1,
      ST_PAD2 = 2'd2,
      ST_EMIT = 2'd3
   } pad_state_t;

   localparam int          BLOCK_BYTES = 64;     // bytes per 512-bit block
   localparam int          LEN_OFS     = 56;     // first byte of the length field
   localparam logic [7:0]  PAD_BYTE    = 8'h80;  // leading '1' bit of the padding

   // H0..H7, H0 in the most significant word
   localparam logic [255:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input and padded-block output of the SHA-256 message padder.
// slave: the padder itself; master: whatever feeds bytes and consumes blocks.
interface sha256_msg_padder_if;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         in_last;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_words;
   logic         blk_first;
   logic         blk_last;

   modport slave (
      input  in_valid, in_data, in_last, blk_ready,
      output in_ready, blk_valid, blk_words, blk_first, blk_last
   );

   modport master (
      output in_valid, in_data, in_last, blk_ready,
      input  in_ready, blk_valid, blk_words, blk_first, blk_last
   );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: collects bytes into a 64-byte block buffer, appends
// the 0x80 marker, zero fill and the 64-bit big-endian bit length, and hands
// blocks (w0 in [511:480]) to the compression core together with first/last
// flags. Optional block/message counters are enabled by SHA256_PAD_BLKCNT_EN.
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   sha256_msg_padder_if.slave   bus
`ifdef SHA256_PAD_BLKCNT_EN
   ,
   output logic [15:0]          blk_count,
   output logic [15:0]          msg_count
`endif
);

   pad_state_t         state_reg,    state_next;
   logic [511:0]       buf_reg,      buf_next;
   logic [6:0]         p_reg,        p_next;       // 0..64, next byte slot
   logic [LEN_W-1:0]   bitlen_reg,   bitlen_next;
   logic               first_reg,    first_next;
   logic               last_reg,     last_next;
   logic               need_len_reg, need_len_next; // length goes in an extra block
   logic               pad80_reg,    pad80_next;    // extra block also carries 0x80

   logic [63:0]        len64;
   logic               wr_en;
   logic [6:0]         wr_idx;
   logic [7:0]         wr_val;
   logic               blk_hs;

   assign blk_hs = (state_reg == ST_EMIT) && bus.blk_ready;

   // Length field is the bit counter zero-extended to 64 bits
   always_comb begin
      len64 = 64'(bitlen_reg);
   end

   // Next-state logic: byte capture, padding insertion and block hand-over
   always_comb begin
      state_next    = state_reg;
      buf_next      = buf_reg;
      p_next        = p_reg;
      bitlen_next   = bitlen_reg;
      first_next    = first_reg;
      last_next     = last_reg;
      need_len_next = need_len_reg;
      pad80_next    = pad80_reg;
      wr_en         = 1'b0;
      wr_idx        = p_reg;
      wr_val        = PAD_BYTE;

      case (state_reg)
         ST_FILL: begin
            if (bus.in_valid) begin
               wr_en       = 1'b1;
               wr_val      = bus.in_data;
               p_next      = p_reg + 7'd1;
               bitlen_next = bitlen_reg + LEN_W'(8);
               if (bus.in_last) begin
                  state_next = ST_PAD;
               end else if (p_reg == 7'(BLOCK_BYTES - 1)) begin
                  state_next = ST_EMIT;
               end
            end
         end

         ST_PAD: begin
            if (p_reg < 7'(LEN_OFS)) begin
               // marker and length both fit: this is the final block
               wr_en          = 1'b1;
               buf_next[63:0] = len64;
               last_next      = 1'b1;
               need_len_next  = 1'b0;
               pad80_next     = 1'b0;
            end else if (p_reg < 7'(BLOCK_BYTES)) begin
               // marker fits, length spills into one more block
               wr_en          = 1'b1;
               last_next      = 1'b0;
               need_len_next  = 1'b1;
               pad80_next     = 1'b0;
            end else begin
               // block completely full: marker and length both spill
               last_next      = 1'b0;
               need_len_next  = 1'b1;
               pad80_next     = 1'b1;
            end
            state_next = ST_EMIT;
         end

         ST_EMIT: begin
            if (bus.blk_ready) begin
               buf_next = '0;
               p_next   = 7'd0;
               if (last_reg) begin
                  first_next    = 1'b1;
                  bitlen_next   = '0;
                  last_next     = 1'b0;
                  need_len_next = 1'b0;
                  pad80_next    = 1'b0;
                  state_next    = ST_FILL;
               end else if (need_len_reg) begin
                  state_next = ST_PAD2;
               end else begin
                  first_next = 1'b0;
                  state_next = ST_FILL;
               end
            end
         end

         ST_PAD2: begin
            buf_next = '0;
            if (pad80_reg) begin
               buf_next[511:504] = PAD_BYTE;
            end
            buf_next[63:0] = len64;
            last_next      = 1'b1;
            first_next     = 1'b0;
            need_len_next  = 1'b0;
            pad80_next     = 1'b0;
            state_next     = ST_EMIT;
         end

         default: begin
            state_next = ST_FILL;
         end
      endcase

      // Byte-lane write decode; lane 0 sits in the top byte of w0
      if (wr_en) begin
         for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (wr_idx == 7'(i)) begin
               buf_next[511 - 8*i -: 8] = wr_val;
            end
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_FILL;
         buf_reg      <= '0;
         p_reg        <= 7'd0;
         bitlen_reg   <= '0;
         first_reg    <= 1'b1;
         last_reg     <= 1'b0;
         need_len_reg <= 1'b0;
         pad80_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         buf_reg      <= buf_next;
         p_reg        <= p_next;
         bitlen_reg   <= bitlen_next;
         first_reg    <= first_next;
         last_reg     <= last_next;
         need_len_reg <= need_len_next;
         pad80_reg    <= pad80_next;
      end
   end

   assign bus.in_ready  = (state_reg == ST_FILL);
   assign bus.blk_valid = (state_reg == ST_EMIT);
   assign bus.blk_words = buf_reg;
   assign bus.blk_first = first_reg;
   assign bus.blk_last  = last_reg;

`ifdef SHA256_PAD_BLKCNT_EN
   // Count blocks handed over and messages completed since reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blk_count <= 16'd0;
         msg_count <= 16'd0;
      end else if (blk_hs) begin
         blk_count <= blk_count + 16'd1;
         if (last_reg) begin
            msg_count <= msg_count + 16'd1;
         end
      end
   end
`else
   logic unused_hs;
   assign unused_hs = blk_hs;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder: a queue-based padding model builds
// the expected blocks for each message; a driver and a block consumer run
// concurrently with random gaps and backpressure. SHA256_PAD_BLKCNT_EN adds
// counter checks.
module tb_sha256_msg_padder;

   typedef byte unsigned bq_t[$];

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   sha256_msg_padder_if bus ();

`ifdef SHA256_PAD_BLKCNT_EN
   logic [15:0] blk_count;
   logic [15:0] msg_count;
`endif

   sha256_msg_padder #(.LEN_W(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef SHA256_PAD_BLKCNT_EN
      ,
      .blk_count (blk_count),
      .msg_count (msg_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   logic [511:0] exp_words[$];
   bit           exp_first[$];
   bit           exp_last[$];
   bit           exp_pad2[$];
   logic [511:0] got_words[$];
   int           hs_count = 0;
   int           msg_hs   = 0;

   task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: pad the whole message as a byte list, then cut into 64-byte blocks
   function automatic void build_model(input bq_t m);
      bq_t pb;
      longint unsigned bits;
      int nblk;
      exp_words.delete();
      exp_first.delete();
      exp_last.delete();
      exp_pad2.delete();
      pb = m;
      pb.push_back(8'h80);
      while (pb.size() % 64 != 56) pb.push_back(8'h00);
      bits = longint'(m.size()) * 8;
      for (int k = 7; k >= 0; k--) pb.push_back(8'(bits >> (8*k)));
      nblk = pb.size() / 64;
      for (int b = 0; b < nblk; b++) begin
         logic [511:0] w;
         w = '0;
         for (int j = 0; j < 64; j++) w = (w << 8) | 512'(pb[b*64 + j]);
         exp_words.push_back(w);
         exp_first.push_back(b == 0);
         exp_last.push_back(b == nblk - 1);
         exp_pad2.push_back(m.size() <= 64*b);
      end
   endfunction

   // Feed bytes; starts and ends 1 time unit after a rising edge
   task automatic drive_msg(input bq_t m, input bit mark_last);
      for (int i = 0; i < m.size(); i++) begin
         int gap;
         int t;
         gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         bus.in_valid = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = m[i];
         bus.in_last  = mark_last && (i == m.size() - 1);
         t = 0;
         forever begin
            @(negedge clk);
            if (bus.in_ready) begin
               @(posedge clk);
               #1;
               break;
            end
            @(posedge clk);
            #1;
            t++;
            if (t > 2000) begin
               check_val("drv_timeout", 0, 1);
               bus.in_valid = 1'b0;
               bus.in_last  = 1'b0;
               return;
            end
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Accept nblk blocks with random stalls, checking each against the model
   task automatic consume(input int nblk, input int stall_min, input int stall_max);
      for (int b = 0; b < nblk; b++) begin
         int w;
         int stall;
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (!bus.blk_valid && w < 3000);
         if (!bus.blk_valid) begin
            check_val("blk_timeout", 0, 1);
            return;
         end
         if (exp_pad2[b]) check_val("pad2_latency", 512'(w), 512'd2);
         got_words.push_back(bus.blk_words);
         check_val($sformatf("words_b%0d", b), bus.blk_words, exp_words[b]);
         check_val($sformatf("first_b%0d", b), 512'(bus.blk_first), 512'(exp_first[b]));
         check_val($sformatf("last_b%0d", b), 512'(bus.blk_last), 512'(exp_last[b]));
         stall = $urandom_range(stall_max, stall_min);
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_val("stall_valid", 512'(bus.blk_valid), 512'd1);
            check_val("stall_words", bus.blk_words, exp_words[b]);
            check_val("stall_flags", 512'({bus.blk_first, bus.blk_last}),
                      512'({exp_first[b], exp_last[b]}));
            check_val("stall_in_ready", 512'(bus.in_ready), 512'd0);
         end
         bus.blk_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.blk_ready = 1'b0;
         hs_count++;
         if (exp_last[b]) msg_hs++;
         check_val("post_hs_valid", 512'(bus.blk_valid), 512'd0);
`ifdef SHA256_PAD_BLKCNT_EN
         check_val("blk_count", 512'(blk_count), 512'(16'(hs_count)));
         check_val("msg_count", 512'(msg_count), 512'(16'(msg_hs)));
`endif
      end
   endtask

   task automatic run_msg(input bq_t m, input int stall_min, input int stall_max);
      build_model(m);
      got_words.delete();
      fork
         drive_msg(m, 1'b1);
         consume(exp_words.size(), stall_min, stall_max);
      join
      $display("msg len=%0d blocks=%0d checks=%0d errors=%0d", m.size(), exp_words.size(), checks, errors);
   endtask

   function automatic bq_t fill_bytes(input int n, input bit rnd);
      bq_t m;
      for (int i = 0; i < n; i++) m.push_back(rnd ? 8'($urandom) : 8'h61);
      return m;
   endfunction

   function automatic logic [31:0] word_of(input logic [511:0] blk, input int idx);
      return blk[511 - 32*idx -: 32];
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bq_t m;
      int lens[13] = '{1, 2, 54, 57, 63, 65, 100, 119, 120, 121, 127, 128, 130};

      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_last   = 1'b0;
      bus.blk_ready = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_blk_valid", 512'(bus.blk_valid), 512'd0);
      check_val("rst_blk_words", bus.blk_words, 512'd0);
      check_val("rst_blk_first", 512'(bus.blk_first), 512'd1);
      check_val("rst_blk_last", 512'(bus.blk_last), 512'd0);
`ifdef SHA256_PAD_BLKCNT_EN
      check_val("rst_counts", 512'({blk_count, msg_count}), 512'd0);
`endif
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_val("rst_in_ready", 512'(bus.in_ready), 512'd1);

      // "abc"
      m = '{8'h61, 8'h62, 8'h63};
      run_msg(m, 0, 0);
      check_val("abc_w0", 512'(word_of(got_words[0], 0)), 512'h61626380);
      check_val("abc_w15", 512'(word_of(got_words[0], 15)), 512'h18);

      // 55 bytes: single block, length fits exactly
      run_msg(fill_bytes(55, 0), 0, 2);
      check_val("b55_w13", 512'(word_of(got_words[0], 13)), 512'h61616180);
      check_val("b55_w15", 512'(word_of(got_words[0], 15)), 512'h1B8);

      // 56 bytes: marker in first block, length alone in second
      run_msg(fill_bytes(56, 0), 0, 2);
      check_val("b56_a_w14", 512'(word_of(got_words[0], 14)), 512'h80000000);
      check_val("b56_a_w15", 512'(word_of(got_words[0], 15)), 512'h0);
      check_val("b56_b_w15", 512'(word_of(got_words[1], 15)), 512'h1C0);

      // 64 bytes: full data block, then marker+length block
      run_msg(fill_bytes(64, 0), 0, 2);
      check_val("b64_a_w0", 512'(word_of(got_words[0], 0)), 512'h61616161);
      check_val("b64_b_w0", 512'(word_of(got_words[1], 0)), 512'h80000000);
      check_val("b64_b_w15", 512'(word_of(got_words[1], 15)), 512'h200);

      // Backpressure: exactly 10 stall cycles on every block
      run_msg(fill_bytes(20, 1), 10, 10);

      // Boundary lengths, then random lengths
      foreach (lens[i]) run_msg(fill_bytes(lens[i], 1), 0, 3);
      for (int r = 0; r < 10; r++) run_msg(fill_bytes($urandom_range(1, 200), 1), 0, 3);

      // Reset after 30 bytes of an unfinished message
      drive_msg(fill_bytes(30, 1), 1'b0);
      #2 reset = 1'b1;
      #1;
      check_val("mid_rst_valid", 512'(bus.blk_valid), 512'd0);
      check_val("mid_rst_words", bus.blk_words, 512'd0);
      check_val("mid_rst_first", 512'(bus.blk_first), 512'd1);
      @(negedge clk);
      reset = 1'b0;
      hs_count = 0;
      msg_hs   = 0;
      @(posedge clk);
      #1;
      m = '{8'h61, 8'h62, 8'h63};
      run_msg(m, 0, 0);
      check_val("abc2_w0", 512'(word_of(got_words[0], 0)), 512'h61626380);
      check_val("abc2_w15", 512'(word_of(got_words[0], 15)), 512'h18);
`ifdef SHA256_PAD_BLKCNT_EN
      check_val("abc2_blk_count", 512'(blk_count), 512'd1);
`endif

      // Reset while a full block waits in EMIT
      drive_msg(fill_bytes(64, 1), 1'b0);
      @(negedge clk);
      check_val("emit_valid", 512'(bus.blk_valid), 512'd1);
      check_val("emit_in_ready", 512'(bus.in_ready), 512'd0);
      #2 reset = 1'b1;
      #1;
      check_val("emit_rst_valid", 512'(bus.blk_valid), 512'd0);
      @(negedge clk);
      reset = 1'b0;
      hs_count = 0;
      msg_hs   = 0;
      @(posedge clk);
      #1;
      run_msg(fill_bytes(5, 1), 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
